// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/flush controller for the 5-stage MIPS pipeline. Generates
//            the PC / IF/ID enables and IF/ID / ID/EX bubble clears from
//            load-use and mult/div hazards. It sequences the multi-cycle
//            mult/div busy window and counts stalled cycles in a saturating
//            counter.
// Options  : PIPE_BRANCH_FLUSH_EN - when defined, a taken branch squashes the
//            wrong-path fetch in IF/ID (no delay slot). When undefined, MIPS
//            delay-slot semantics apply and br_taken is unused.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_rs_use,
    input  logic              id_rt_use,
    input  logic              ex_load,
    input  logic [4:0]        ex_wa,
    input  logic              id_md_use,
    input  logic              ex_md_start,
    input  logic              ex_md_div,
    input  logic              br_taken,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_clr,
    output logic              idex_clr,
    output logic              md_busy,
    output logic              md_done,
    output logic [PERF_W-1:0] perf_stall
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    localparam logic [CNT_W-1:0]  C_MULT_LD  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0]  C_DIV_LD   = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_TWO  = CNT_W'(2);
    localparam logic [PERF_W-1:0] C_PERF_MAX = {PERF_W{1'b1}};
    localparam logic [PERF_W-1:0] C_PERF_ONE = PERF_W'(1);

    md_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_md_busy;
    logic              r_md_done;
    logic [PERF_W-1:0] r_perf;

    logic              w_lu;
    logic              w_mds;
    logic              w_stall;
    logic [CNT_W-1:0]  w_md_ld;

    // Hazard detection: a load writing a register the ID instruction reads,
    // or a HI/LO access while the mult/div unit is busy or just starting.
    always_comb begin
        w_lu    = ex_load && (ex_wa != 5'd0) &&
                  ((id_rs_use && (id_rs == ex_wa)) ||
                   (id_rt_use && (id_rt == ex_wa)));
        w_mds   = id_md_use && (r_md_busy || ex_md_start);
        w_stall = w_lu || w_mds;
        w_md_ld = ex_md_div ? C_DIV_LD : C_MULT_LD;
    end

    // Pipeline enables/clears: a stall freezes PC and IF/ID and lets the EX
    // instruction drain while a bubble enters ID/EX.
    always_comb begin
        pc_en    = ~w_stall;
        ifid_en  = ~w_stall;
        idex_clr = w_stall;
`ifdef PIPE_BRANCH_FLUSH_EN
        // A stalled branch stays in ID and is re-evaluated, so ignore it now.
        ifid_clr = br_taken && !w_stall;
`else
        ifid_clr = 1'b0;
`endif
    end

`ifndef PIPE_BRANCH_FLUSH_EN
    // Delay-slot build: the branch outcome has no effect on this block.
    logic w_unused_br;
    assign w_unused_br = br_taken;
`endif

    // Mult/div busy sequencer; busy/done are registered alongside the state so
    // they are glitch-free. A start while busy is ignored (no reload).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_md_busy <= 1'b0;
            r_md_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ex_md_start) begin
                        r_state   <= ST_BUSY;
                        r_cnt     <= w_md_ld;
                        r_md_busy <= 1'b1;
                        r_md_done <= (w_md_ld == C_CNT_ONE);
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == C_CNT_ONE) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        r_md_busy <= 1'b0;
                        r_md_done <= 1'b0;
                    end else begin
                        r_cnt     <= r_cnt - C_CNT_ONE;
                        r_md_done <= (r_cnt == C_CNT_TWO);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_md_busy <= 1'b0;
                    r_md_done <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles; a combined load-use + md stall
    // counts once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf <= '0;
        end else if (w_stall && (r_perf != C_PERF_MAX)) begin
            r_perf <= r_perf + C_PERF_ONE;
        end
    end

    assign md_busy    = r_md_busy;
    assign md_done    = r_md_done;
    assign perf_stall = r_perf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl: directed scenarios
//            plus randomized traffic compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int P_MULT     = 5;
    localparam int P_DIV      = 10;
    localparam int P_PERF_W   = 4;
    localparam int P_PERF_MAX = (1 << P_PERF_W) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic [4:0]          id_rs, id_rt, ex_wa;
    logic                id_rs_use, id_rt_use, ex_load;
    logic                id_md_use, ex_md_start, ex_md_div, br_taken;
    wire                 pc_en, ifid_en, ifid_clr, idex_clr, md_busy, md_done;
    wire [P_PERF_W-1:0]  perf_stall;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: remaining busy cycles of the mult/div unit, stall count.
    int m_rem  = 0;
    int m_perf = 0;

    pipe_hazard_ctrl #(
        .MULT_CYCLES (P_MULT),
        .DIV_CYCLES  (P_DIV),
        .CNT_W       (4),
        .PERF_W      (P_PERF_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_use   (id_rs_use),
        .id_rt_use   (id_rt_use),
        .ex_load     (ex_load),
        .ex_wa       (ex_wa),
        .id_md_use   (id_md_use),
        .ex_md_start (ex_md_start),
        .ex_md_div   (ex_md_div),
        .br_taken    (br_taken),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_clr    (ifid_clr),
        .idex_clr    (idex_clr),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .perf_stall  (perf_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; ex_wa = 0;
        id_rs_use = 0; id_rt_use = 0; ex_load = 0;
        id_md_use = 0; ex_md_start = 0; ex_md_div = 0; br_taken = 0;
    endtask

    // One clock cycle: inputs are already applied; check every output at the
    // falling edge against the model, then advance the model at the rising edge.
    task automatic cycle();
        bit lu, mds, st, exp_clr;
        @(negedge clk);
        if (!reset) begin
            m_rem  = 0;
            m_perf = 0;
        end
        lu  = ex_load && (ex_wa != 0) &&
              ((id_rs_use && id_rs == ex_wa) || (id_rt_use && id_rt == ex_wa));
        mds = id_md_use && ((m_rem > 0) || ex_md_start);
        st  = lu || mds;
`ifdef PIPE_BRANCH_FLUSH_EN
        exp_clr = br_taken && !st;
`else
        exp_clr = 1'b0;
`endif
        check("pc_en",      32'(pc_en),      32'(!st));
        check("ifid_en",    32'(ifid_en),    32'(!st));
        check("idex_clr",   32'(idex_clr),   32'(st));
        check("ifid_clr",   32'(ifid_clr),   32'(exp_clr));
        check("md_busy",    32'(md_busy),    32'(m_rem > 0));
        check("md_done",    32'(md_done),    32'(m_rem == 1));
        check("perf_stall", 32'(perf_stall), 32'(m_perf));
        @(posedge clk);
        if (reset) begin
            if (st && m_perf < P_PERF_MAX) m_perf++;
            if (m_rem > 0)        m_rem--;
            else if (ex_md_start) m_rem = ex_md_div ? P_DIV : P_MULT;
        end
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    initial begin : main
        int busy_seen, done_seen, done_pos;
        idle_inputs();
        reset = 1'b0;
        #1;
        do_reset();
        cycle();

        // Load-use hazard on rs
        ex_load = 1; ex_wa = 8; id_rs_use = 1; id_rs = 8;
        cycle();
        idle_inputs();
        cycle();
        check("lu_perf", 32'(perf_stall), 32'd1);

        // Same stimulus with $zero destination: no stall
        ex_load = 1; ex_wa = 0; id_rs_use = 1; id_rs = 0;
        cycle();
        idle_inputs();
        cycle();
        check("zero_perf", 32'(perf_stall), 32'd1);

        // Load-use hazard on rt only
        ex_load = 1; ex_wa = 17; id_rt_use = 1; id_rt = 17; id_rs_use = 1; id_rs = 3;
        cycle();
        idle_inputs();

        // Mult sequencing with id_md_use held
        do_reset();
        ex_md_start = 1; ex_md_div = 0; id_md_use = 1;
        cycle();
        ex_md_start = 0;
        busy_seen = 0; done_seen = 0; done_pos = -1;
        for (int i = 0; i < 8; i++) begin
            if (md_busy) busy_seen++;
            if (md_done) begin done_seen++; done_pos = i; end
            cycle();
        end
        check("mult_busy_cycles", 32'(busy_seen), 32'd5);
        check("mult_done_count",  32'(done_seen), 32'd1);
        check("mult_done_pos",    32'(done_pos),  32'd4);
        check("mult_perf",        32'(perf_stall), 32'd6);
        idle_inputs();

        // Div interrupted by reset after 4 busy cycles
        do_reset();
        ex_md_start = 1; ex_md_div = 1;
        cycle();
        idle_inputs();
        for (int i = 0; i < 4; i++) cycle();
        check("div_busy_before_rst", 32'(md_busy), 32'd1);
        reset = 1'b0;
        #1;
        check("div_busy_in_rst", 32'(md_busy), 32'd0);
        cycle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("div_busy_after_rst", 32'(md_busy), 32'd0);

        // Saturation: hold a load-use stall for 20 cycles
        do_reset();
        ex_load = 1; ex_wa = 5; id_rs_use = 1; id_rs = 5;
        for (int i = 0; i < 20; i++) cycle();
        check("sat_perf", 32'(perf_stall), 32'(P_PERF_MAX));
        cycle();
        check("sat_hold", 32'(perf_stall), 32'(P_PERF_MAX));
        idle_inputs();

        // Branch alone, then branch with a load-use hazard
        do_reset();
        br_taken = 1;
        cycle();
        ex_load = 1; ex_wa = 8; id_rs_use = 1; id_rs = 8;
        cycle();
        idle_inputs();

        // Randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 500; i++) begin
            ex_load     = 1'($urandom_range(0, 1));
            ex_wa       = 5'($urandom_range(0, 3));
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_rs_use   = 1'($urandom_range(0, 1));
            id_rt_use   = 1'($urandom_range(0, 1));
            id_md_use   = ($urandom_range(0, 2) == 0);
            ex_md_start = ($urandom_range(0, 6) == 0);
            ex_md_div   = 1'($urandom_range(0, 1));
            br_taken    = 1'($urandom_range(0, 1));
            reset       = ($urandom_range(0, 49) != 0);
            #0;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage MIPS pipeline.
- Drives the enable and clear inputs of the PC, the IF/ID pipeline register and the ID/EX pipeline register.
- Sources of stall and flush:
  - load-use hazards;
  - a multi-cycle mult/div unit, whose busy window this block sequences with an internal FSM/counter;
  - optionally, taken branches.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1, must fit CNT_W).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1, must fit CNT_W).
- CNT_W, 4, width of the mult/div countdown counter.
- PERF_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_rs_use  in  1  ID instruction reads rs.
- id_rt_use  in  1  ID instruction reads rt.
- ex_load  in  1  EX instruction is a load.
- ex_wa  in  5  destination register of the EX instruction.
- id_md_use  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- ex_md_start  in  1  EX instruction starts mult/div this cycle.
- ex_md_div  in  1  1 = div, 0 = mult (valid with ex_md_start).
- br_taken  in  1  branch/jump in ID resolved taken.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_clr  out  1  IF/ID synchronous clear (bubble).
- idex_clr  out  1  ID/EX synchronous clear (bubble).
- md_busy  out  1  mult/div unit busy (registered).
- md_done  out  1  last busy cycle of mult/div (registered).
- perf_stall  out  PERF_W  count of stalled cycles.

Behaviour:
- Load-use stall (combinational): lu = ex_load & (ex_wa != 0) & ((id_rs_use & id_rs == ex_wa) | (id_rt_use & id_rt == ex_wa)).
- MD stall (combinational): mds = id_md_use & (md_busy | ex_md_start).
- stall = lu | mds.
- Stall effect:
  - pc_en = ifid_en = ~stall.
  - idex_clr = stall: a bubble is inserted and the EX instruction proceeds.
- Stall duration: a load-use stall lasts exactly 1 cycle, because the next cycle the load is in MEM.
- MD FSM states: IDLE, BUSY.
  - IDLE -> BUSY: on an edge with ex_md_start=1; cnt loaded with MULT_CYCLES or DIV_CYCLES, selected by ex_md_div.
  - In BUSY:
    - cnt decrements by 1 per edge.
    - When cnt==1 at an edge: BUSY -> IDLE, cnt -> 0.
  - md_busy = (state == BUSY): high for exactly N cycles, starting the cycle after the start edge.
  - md_done = BUSY & (cnt == 1): a single-cycle pulse in the last busy cycle.
- ex_md_start while BUSY: ignored. No reload, no extension. (This cannot occur legally, since mds holds the instruction in ID.)
- perf_stall:
  - +1 on every edge where stall=1.
  - Saturates at all-ones; no wrap.
- Reset (reset=0, any time, including mid-BUSY):
  - state = IDLE, cnt = 0, md_busy = 0, md_done = 0, perf_stall = 0.
  - Combinational outputs then follow the inputs. With idle inputs: pc_en=1, ifid_en=1, ifid_clr=0, idex_clr=0.
- Simultaneous load-use and md stall: a single stall; perf_stall +1 only.
- ex_wa == 0: never causes a load-use stall ($zero).

Optional Feature:
- Macro PIPE_BRANCH_FLUSH_EN.
- Defined (no delay slot):
  - ifid_clr = br_taken & ~stall; the wrong-path fetch in IF/ID is squashed.
  - While stalled, br_taken is ignored, since the branch stays in ID and is re-evaluated.
- Undefined (MIPS delay-slot semantics): ifid_clr tied to 0; br_taken unused.

Test Plan:
- Reset check: reset=0 mid-run with all inputs 0 -> md_busy=0, md_done=0, perf_stall=0, pc_en=1, ifid_en=1, idex_clr=0, ifid_clr=0.
- Load-use:
  - ex_load=1, ex_wa=8, id_rs_use=1, id_rs=8 for one cycle -> pc_en=0, ifid_en=0, idex_clr=1 that cycle; perf_stall=1 after.
  - Same stimulus with ex_wa=0 -> no stall.
- Mult sequencing: ex_md_start=1, ex_md_div=0 for one cycle -> md_busy=1 for exactly 5 cycles, md_done=1 only in the 5th. With id_md_use=1 held throughout: stall on the start cycle plus all 5 busy cycles, perf_stall=6.
- Div with reset mid-operation: ex_md_start=1, ex_md_div=1, then reset=0 after 4 busy cycles -> md_busy=0 immediately; after release, md_busy stays 0 with ex_md_start=0.
- Saturation: PERF_W=4, hold a stall for 20 cycles -> perf_stall=15 and stays 15.
- Branch (macro defined): br_taken=1, no hazard -> ifid_clr=1. br_taken=1 together with the load-use hazard above -> ifid_clr=0, idex_clr=1. Macro undefined -> ifid_clr=0 always.
